shr_frame_rx: RTL

SHR_FRAME_RX -- requirements
Module: shr_frame_rx

---
 rtl/shr_pkg.sv | 16 +
 rtl/shr_sync3.sv | 32 +++
 rtl/shr_frame_rx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/shr_pkg.sv
// Shared constants for the SHR serial frame link: receiver state encoding and
// error codes, also used by the upstream serializer's bench.
package shr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FLUSH = 2'd2
    } shr_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_SHORT   = 2'b01;
    localparam logic [1:0] ERR_LONG    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/shr_sync3.sv
// Two-flop synchronizer with a trailing delay flop, giving the synchronized
// level plus single-cycle rise and fall strobes in the clk_in domain.
module shr_sync3 (
    input  logic clk_in,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~dly_q;
    assign fall  = ~sync_q & dly_q;

endmodule

// File: rtl/shr_frame_rx.sv
// Receiver for the SHR GPIO serial link: oversamples ser_clk/ser_din/ser_syn
// in the clk_in domain, assembles MSB-first frames and judges their length.
module shr_frame_rx
    import shr_pkg::*;
#(
    parameter int FRAME_BITS  = 24,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  ser_clk,
    input  logic                  ser_din,
    input  logic                  ser_syn,
    output logic [FRAME_BITS-1:0] data_out,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [1:0]            err_code,
    output logic [15:0]           frame_cnt,
    output logic                  busy
);

    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] FB_C  = CNT_W'(FRAME_BITS);
    localparam logic [TMO_W-1:0] TMO_C = TMO_W'(TIMEOUT_CYC);

    logic sclk_rise;
    logic sclk_level_unused;
    logic sclk_fall_unused;
    logic din_s;
    logic din_rise_unused;
    logic din_fall_unused;
    logic syn_level;
    logic syn_rise;
    logic syn_fall;

    shr_sync3 u_sync_clk (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .din    (ser_clk),
        .level  (sclk_level_unused),
        .rise   (sclk_rise),
        .fall   (sclk_fall_unused)
    );

    shr_sync3 u_sync_din (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .din    (ser_din),
        .level  (din_s),
        .rise   (din_rise_unused),
        .fall   (din_fall_unused)
    );

    shr_sync3 u_sync_syn (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .din    (ser_syn),
        .level  (syn_level),
        .rise   (syn_rise),
        .fall   (syn_fall)
    );

    shr_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [FRAME_BITS-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [1:0]            code_q, code_d;
    logic [15:0]           fcnt_q, fcnt_d;
    logic                  tmo_hit;

    assign tmo_hit = (state_q == ST_SHIFT) && (tmo_q == TMO_C);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (syn_rise) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (syn_fall)     state_d = ST_IDLE;
                else if (tmo_hit) state_d = ST_FLUSH;
            end
            ST_FLUSH: if (!syn_level) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Bit assembly: the register freezes once the frame is already too long,
    // so only the first FRAME_BITS bits are ever kept.
    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (syn_rise) begin
                    cnt_d   = '0;
                    shreg_d = '0;
                    tmo_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    if (cnt_q < FB_C)  shreg_d = {shreg_q[FRAME_BITS-2:0], din_s};
                    if (cnt_q <= FB_C) cnt_d = cnt_q + 1'b1;
                    tmo_d = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shreg_q <= '0;
            tmo_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            tmo_q   <= tmo_d;
        end
    end

    // Frame judgement uses cnt_d/shreg_d so a bit arriving with the syn fall counts.
    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        fcnt_d  = fcnt_q;
        if (state_q == ST_SHIFT) begin
            if (syn_fall) begin
                if (cnt_d == FB_C) begin
                    data_d  = shreg_d;
                    valid_d = 1'b1;
                    fcnt_d  = fcnt_q + 16'd1;
                    code_d  = ERR_NONE;
                end else if (cnt_d < FB_C) begin
                    err_d  = 1'b1;
                    code_d = ERR_SHORT;
                end else begin
                    err_d  = 1'b1;
                    code_d = ERR_LONG;
                end
            end else if (tmo_hit) begin
                err_d  = 1'b1;
                code_d = ERR_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            fcnt_q  <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            code_q  <= code_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign data_out    = data_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign err_code    = code_q;
    assign frame_cnt   = fcnt_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
